// File: rtl/id_pkg.sv
// Shared types for the decode stage: format codes, base opcodes and the decoded bundle.
// Bundle pc/imm are sized for the widest XLEN; narrower builds use the low bits.
package id_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_INVALID = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [MAX_XLEN-1:0] imm;
    fmt_e                format;
    logic                illegal;
  } dec_bundle_t;

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] value);
    return {{(MAX_XLEN-32){value[31]}}, value};
  endfunction

endpackage

// File: rtl/id_stage_field_decode.sv
// Combinational RISC-V base-instruction field decoder: instruction + PC -> decoded bundle.
module field_decode
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_bundle_t     dec
);

  fmt_e        fmt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    fmt = FMT_INVALID;
    case (instr[6:0])
      OP_OP:                     fmt = FMT_R;
      OP_OP_32:                  if (XLEN == 64) fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_IMM_32:                 if (XLEN == 64) fmt = FMT_I;
      OP_STORE:                  fmt = FMT_S;
      OP_BRANCH:                 fmt = FMT_B;
      OP_LUI, OP_AUIPC:          fmt = FMT_U;
      OP_JAL:                    fmt = FMT_J;
      default:                   fmt = FMT_INVALID;
    endcase
  end

  // Fields a format does not carry stay zero so downstream never sees stale indices.
  always_comb begin
    dec              = '0;
    dec.pc[XLEN-1:0] = pc;
    dec.opcode       = instr[6:0];
    dec.format       = fmt;
    dec.illegal      = (fmt == FMT_INVALID);
    case (fmt)
      FMT_R: begin
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
      end
      FMT_I: begin
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.imm    = sext32(imm_i);
      end
      FMT_S: begin
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.imm    = sext32(imm_s);
      end
      FMT_B: begin
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.imm    = sext32(imm_b);
      end
      FMT_U: begin
        dec.rd  = instr[11:7];
        dec.imm = sext32(imm_u);
      end
      FMT_J: begin
        dec.rd  = instr[11:7];
        dec.imm = sext32(imm_j);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: decodes on the input side, holds bundles in an output
// register plus a one-entry skid buffer, with valid/ready on both sides and flush.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_format,
  output logic            out_illegal
);

  dec_bundle_t dec_next;
  dec_bundle_t out_reg;
  dec_bundle_t skid_reg;
  logic        out_valid_reg;
  logic        skid_valid_reg;
  logic        accept;
  state_e      state;

  field_decode #(.XLEN(XLEN)) u_field_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_next)
  );

  // Registered-only ready: no combinational path from out_ready.
  assign in_ready = !skid_valid_reg && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    if (skid_valid_reg)     state = ST_SKID;
    else if (out_valid_reg) state = ST_FULL;
    else                    state = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_reg        <= '0;
      out_reg.format <= FMT_INVALID;
      skid_reg       <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_reg       <= dec_next;
            out_valid_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (accept) out_reg <= dec_next;
            else        out_valid_reg <= 1'b0;
          end else if (accept) begin
            skid_reg       <= dec_next;
            skid_valid_reg <= 1'b1;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            out_reg        <= skid_reg;
            skid_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_pc      = out_reg.pc[XLEN-1:0];
  assign out_opcode  = out_reg.opcode;
  assign out_rd      = out_reg.rd;
  assign out_rs1     = out_reg.rs1;
  assign out_rs2     = out_reg.rs2;
  assign out_funct3  = out_reg.funct3;
  assign out_funct7  = out_reg.funct7;
  assign out_imm     = out_reg.imm[XLEN-1:0];
  assign out_format  = out_reg.format;
  assign out_illegal = out_reg.illegal;

  // Upper pc/imm bits only matter when XLEN is below the bundle width.
  logic unused_hi;
  assign unused_hi = ^{out_reg.pc, out_reg.imm};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: field-decode vector table on XLEN=64 and XLEN=32
// instances, plus hand-written handshake, flush and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_pc64, out_imm64;
  logic [6:0]  out_opcode64, out_funct7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_funct3_64, out_format64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_pc32, out_imm32;
  logic [6:0]  out_opcode32, out_funct7_32;
  logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
  logic [2:0]  out_funct3_32, out_format32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
    .out_funct3(out_funct3_64), .out_funct7(out_funct7_64), .out_imm(out_imm64),
    .out_format(out_format64), .out_illegal(out_illegal64)
  );

  id_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
    .out_opcode(out_opcode32), .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32),
    .out_funct3(out_funct3_32), .out_funct7(out_funct7_32), .out_imm(out_imm32),
    .out_format(out_format32), .out_illegal(out_illegal32)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rv64_only;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi_rd(input int rd);
    logic [4:0] r;
    r = rd[4:0];
    return {12'd0, 5'd0, 3'd0, r, 7'b0010011};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [63:0] pc;
    logic        ill32;
    int          sent;
    int          recv;
    logic        acc;
    logic        fire;

    vecs[0]  = '{"addi",  32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 1'b0};
    vecs[1]  = '{"jal",   32'h008000EF, 64'h8,                   3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0};
    vecs[2]  = '{"addiw", 32'h0010009B, 64'h1,                   3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1'b1};
    vecs[3]  = '{"sw",    32'hFE21AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 5'd0, 5'd3, 5'd2, 3'd2, 7'h00, 1'b0};
    vecs[4]  = '{"lui",   32'h80000037, 64'hFFFF_FFFF_8000_0000, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0};
    vecs[5]  = '{"sub",   32'h402081B3, 64'h0,                   3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 1'b0};
    vecs[6]  = '{"bne",   32'h00209863, 64'h10,                  3'd3, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 1'b0};
    vecs[7]  = '{"addw",  32'h002080BB, 64'h0,                   3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 1'b1};
    vecs[8]  = '{"auipc", 32'h00001297, 64'h1000,                3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0};
    vecs[9]  = '{"bad",   32'hFFFFFFFF, 64'h0,                   3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 1'b0};
    vecs[10] = '{"lw",    32'hFF812283, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h7F, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready64", {63'd0, in_ready64}, 64'd0);
    chk("rst_in_ready32", {63'd0, in_ready32}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("rst_format", {61'd0, out_format64}, 64'd7);
    chk("rst_illegal", {63'd0, out_illegal64}, 64'd0);
    chk("rst_imm", out_imm64, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready64}, 64'd1);

    // Field-decode table, one instruction per cycle with out_ready high
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      pc = 64'h2000 + 64'(4 * i);
      in_instr = v.instr;
      in_pc    = pc;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      ill32 = v.rv64_only || (v.fmt == 3'd7);
      chk({v.name, ".valid64"},  {63'd0, out_valid64}, 64'd1);
      chk({v.name, ".pc64"},     out_pc64, pc);
      chk({v.name, ".opcode64"}, {57'd0, out_opcode64}, {57'd0, v.instr[6:0]});
      chk({v.name, ".fmt64"},    {61'd0, out_format64}, {61'd0, v.fmt});
      chk({v.name, ".ill64"},    {63'd0, out_illegal64}, {63'd0, v.fmt == 3'd7});
      chk({v.name, ".imm64"},    out_imm64, v.imm);
      chk({v.name, ".rd64"},     {59'd0, out_rd64}, {59'd0, v.rd});
      chk({v.name, ".rs1_64"},   {59'd0, out_rs1_64}, {59'd0, v.rs1});
      chk({v.name, ".rs2_64"},   {59'd0, out_rs2_64}, {59'd0, v.rs2});
      chk({v.name, ".f3_64"},    {61'd0, out_funct3_64}, {61'd0, v.f3});
      chk({v.name, ".f7_64"},    {57'd0, out_funct7_64}, {57'd0, v.f7});
      chk({v.name, ".valid32"},  {63'd0, out_valid32}, 64'd1);
      chk({v.name, ".pc32"},     {32'd0, out_pc32}, {32'd0, pc[31:0]});
      chk({v.name, ".opcode32"}, {57'd0, out_opcode32}, {57'd0, v.instr[6:0]});
      chk({v.name, ".fmt32"},    {61'd0, out_format32}, ill32 ? 64'd7 : {61'd0, v.fmt});
      chk({v.name, ".ill32"},    {63'd0, out_illegal32}, {63'd0, ill32});
      chk({v.name, ".imm32"},    {32'd0, out_imm32}, ill32 ? 64'd0 : {32'd0, v.imm[31:0]});
      chk({v.name, ".rd32"},     {59'd0, out_rd32}, ill32 ? 64'd0 : {59'd0, v.rd});
      chk({v.name, ".rs1_32"},   {59'd0, out_rs1_32}, ill32 ? 64'd0 : {59'd0, v.rs1});
      chk({v.name, ".rs2_32"},   {59'd0, out_rs2_32}, ill32 ? 64'd0 : {59'd0, v.rs2});
      chk({v.name, ".f3_32"},    {61'd0, out_funct3_32}, ill32 ? 64'd0 : {61'd0, v.f3});
      chk({v.name, ".f7_32"},    {57'd0, out_funct7_32}, ill32 ? 64'd0 : {57'd0, v.f7});
      $display("vec %-6s instr=%08h fmt64=%0d imm64=%016h fmt32=%0d imm32=%08h",
               v.name, v.instr, out_format64, out_imm64, out_format32, out_imm32);
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", {63'd0, out_valid64}, 64'd0);

    // Back-to-back five with out_ready low in cycles 2..4
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = (sent < 5);
      in_instr  = addi_rd(sent + 1);
      in_pc     = 64'h100 + 64'(4 * sent);
      #1;
      if (c == 2) chk("b2b_in_ready_drop", {63'd0, in_ready64}, 64'd0);
      acc  = in_valid && in_ready64;
      fire = out_valid64 && out_ready;
      if (fire) begin
        chk("b2b_pc", out_pc64, 64'h100 + 64'(4 * recv));
        chk("b2b_rd", {59'd0, out_rd64}, 64'(recv + 1));
        $display("b2b out #%0d pc=%0h rd=%0d cycle=%0d", recv, out_pc64, out_rd64, c);
        recv++;
      end
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("b2b_count", 64'(recv), 64'd5);
    repeat (2) begin
      chk("b2b_no_dup", {63'd0, out_valid64}, 64'd0);
      @(negedge clk);
    end

    // Flush while in SKID with an input presented
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = addi_rd(10); in_pc = 64'h300;
    @(negedge clk);
    in_instr = addi_rd(11); in_pc = 64'h304;
    @(negedge clk);
    chk("skid_in_ready", {63'd0, in_ready64}, 64'd0);
    flush = 1'b1; in_instr = addi_rd(12); in_pc = 64'h308;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready64}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_ghost", {63'd0, out_valid64}, 64'd0);
    end
    $display("flush in SKID done");

    // Flush while FULL: in_ready stays high but the input is dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = addi_rd(13); in_pc = 64'h400;
    @(negedge clk);
    flush = 1'b1; in_instr = addi_rd(14); in_pc = 64'h404;
    #1;
    chk("flush_cycle_in_ready", {63'd0, in_ready64}, 64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_out_valid", {63'd0, out_valid64}, 64'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = addi_rd(15); in_pc = 64'h500;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_flush_valid", {63'd0, out_valid64}, 64'd1);
    chk("post_flush_pc", out_pc64, 64'h500);
    chk("post_flush_rd", {59'd0, out_rd64}, 64'd15);
    $display("flush in FULL done");
    @(negedge clk);

    // Reset while FULL and stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE21AE23; in_pc = 64'h600;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_full", {63'd0, out_valid64}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_full_in_ready", {63'd0, in_ready64}, 64'd0);
    @(negedge clk);
    chk("rst_full_out_valid", {63'd0, out_valid64}, 64'd0);
    chk("rst_full_format", {61'd0, out_format64}, 64'd7);
    chk("rst_full_illegal", {63'd0, out_illegal64}, 64'd0);
    chk("rst_full_pc", out_pc64, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_full_in_ready_after", {63'd0, in_ready64}, 64'd1);
    $display("reset in FULL done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised instruction-decode stage that splits a 32-bit RISC-V base instruction into register indices, funct fields, a sign-extended immediate, a format code and an illegal flag. It sits between fetch and execute and carries the PC alongside. It adds three things to the purely combinational field decoder:

- an XLEN parameter (RV32I/RV64I);
- valid/ready handshakes on both sides, with a one-entry skid buffer;
- pipeline flush.

## Interface
Parameters:
- XLEN, 64, datapath width; only 32 or 64 legal. RV64-only opcodes (0011011, 0111011) are legal only when XLEN==64.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  discard all held instructions
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  raw instruction
- in_pc  input  XLEN  PC of in_instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts the bundle
- out_pc  output  XLEN  PC of the decoded instruction
- out_opcode  output  7  instr[6:0]
- out_rd, out_rs1, out_rs2  output  5 each  register indices; 0 when the format has no such field
- out_funct3  output  3  instr[14:12] for R/I/S/B; else 0
- out_funct7  output  7  instr[31:25] for R/I; else 0
- out_imm  output  XLEN  sign-extended immediate; 0 for R
- out_format  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, invalid=7
- out_illegal  output  1  opcode not decodable for this XLEN

## Operation
Opcode-to-format mapping:
- 0110011 → R; 0111011 → R when XLEN==64.
- 0010011, 0000011, 1100111 → I; 0011011 → I when XLEN==64.
- 0100011 → S. 1100011 → B.
- 0110111, 0010111 → U. 1101111 → J.
- Anything else → format 7, out_illegal=1, all other fields 0 except out_opcode and out_pc.

Immediate construction (raw immediate sign-extended from instr[31] to XLEN):
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.

Decode is done on the input side. Registers hold the decoded bundle, not the raw instruction.

State machine (derived from out_valid and skid_valid):
- EMPTY: accept → FULL.
- FULL:
  - accept and out_ready → FULL, new bundle.
  - accept and !out_ready → SKID; new bundle goes into the skid entry.
  - no accept and out_ready → EMPTY.
  - otherwise hold.
- SKID: in_ready=0. out_ready → FULL; the skid entry moves to the output register. Otherwise hold.

Handshake and ordering:
- accept = in_valid && in_ready.
- in_ready = !skid_valid && !rst.
- Bundles leave in acceptance order. None is dropped or duplicated except on flush.

Flush:
- Has priority over everything else. Next state is EMPTY.
- An input presented in the flush cycle is not accepted; in_ready is still 1 in that cycle if the skid entry was empty.
- An output handshake in the flush cycle counts as completed.

Reset values: out_valid=0, skid empty, out_format=7, out_illegal=0, all other outputs 0. in_ready=0 while rst is high and 1 in the first cycle after.

## Timing
- Latency: accepted in cycle N → out_valid in cycle N+1.
- Throughput: one per cycle while out_ready=1.
- in_ready depends only on registered state; no combinational path from out_ready to in_ready.
- Output fields are stable while out_valid && !out_ready.
- Field values are don't-care while out_valid=0, but hold the last value (no reload).

## Structure
- Package id_pkg holds:
  - the format enum (R..J, INVALID=7);
  - opcode localparams;
  - a packed struct dec_bundle_t parameterised through XLEN-width fields (pc, opcode, rd, rs1, rs2, funct3, funct7, imm, format, illegal).
- Sub-module field_decode (XLEN parameter): purely combinational, instruction plus PC → dec_bundle_t.
- id_stage contains the output register, the skid register and the control logic.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), XLEN=64, out_ready=1:
  - next cycle out_valid=1, rd=1, rs1=0, funct3=0, format=1, imm=0xFFFF_FFFF_FFFF_FFFF.
  - JAL x1,+8 (0x008000EF) → format=5, rd=1, imm=8.
- Back-to-back: five instructions with out_ready low for cycles 2–4:
  - in_ready drops after the second accept;
  - all five emerge in order and none repeats.
- In SKID state, assert flush for one cycle with in_valid=1:
  - next cycle out_valid=0 and in_ready=1;
  - the flushed input never appears.
- XLEN=32, ADDIW 0x0010009B → format=7, illegal=1. Same instruction at XLEN=64 → format=1, imm=1.
- SW x2,-4(x3) (0xFE21AE23) → format=2, rs1=3, rs2=2, rd=0, imm=−4. At XLEN=32, LUI 0x80000037 → imm=0x8000_0000.
- Assert rst while in FULL with out_ready=0:
  - next cycle out_valid=0, out_format=7;
  - in_ready=0 during reset, 1 afterwards.
